// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// operation codes and the bit-counter width helper.
package serial_addsub_pkg;

    // Controller states: waiting for a request, or stepping through bits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Encoding of the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of a counter that must hold bit indices 0..w-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder. Purely combinational so any serial or ripple
// arithmetic block can reuse it.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s     = x ^ y ^ c_in;
        c_out = (x & y) | (x & c_in) | (y & c_in);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// then one bit per clock (LSB first) passes through a single fa_cell.
// Results are committed together with a one-cycle done pulse.
//
// Handshake: start is a request sampled only while idle (busy=0); a start
// seen while busy is dropped. done is a one-cycle strobe on which s, c_out
// and ovf become valid; they hold until the next completion. A start in the
// done cycle is accepted, so operations can run back to back.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    // The FSM state is kept in a named register so checkers can probe it.
    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             done_q;

    logic             cell_s;
    logic             cell_c;
    logic             accept;
    logic             last_bit;
    logic             finish;

    fa_cell u_fa (
        .x     (op_a_q[0]),
        .y     (op_b_q[0]),
        .c_in  (carry_q),
        .s     (cell_s),
        .c_out (cell_c)
    );

    // Decode of the request and of the completion edge.
    always_comb begin
        accept   = (state_q == IDLE) && start;
        last_bit = (cnt_q == CW'(WIDTH - 1));
        finish   = (state_q == RUN) && last_bit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: run for exactly WIDTH edges after an accepted start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Serial datapath: load on accept, then shift one bit per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_a_q  <= a;
            op_b_q  <= (sub == OP_SUB) ? ~b : b;
            carry_q <= (sub == OP_SUB) ? 1'b1 : c_in;
            part_q  <= '0;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            op_a_q  <= op_a_q >> 1;
            op_b_q  <= op_b_q >> 1;
            part_q  <= {cell_s, part_q[WIDTH-1:1]};
            carry_q <= cell_c;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Result registers change only on the completion edge. On that edge
    // carry_q is the carry into the MSB and cell_c the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                s_q     <= {cell_s, part_q[WIDTH-1:1]};
                c_out_q <= cell_c;
                ovf_q   <= carry_q ^ cell_c;
            end
        end
    end

    // Registered results drive the outputs directly.
    always_comb begin
        s     = s_q;
        c_out = c_out_q;
        ovf   = ovf_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a WIDTH=8 and a WIDTH=3 instance sharing clock
// and reset; table vectors, hand-written multi-cycle sequences and random
// operations checked against an arithmetic reference model.
module tb_serial_addsub;

    logic       clk;
    logic       rst;

    logic       start8, sub8, c_in8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c_out8, ovf8;
    logic [7:0] s8;

    logic       start3, sub3, c_in3;
    logic [2:0] a3, b3;
    logic       busy3, done3, c_out3, ovf3;
    logic [2:0] s3;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [7:0] last_s8 = '0;
    logic [2:0] last_s3 = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[8];

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .c_in  (c_in8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .c_out (c_out8),
        .ovf   (ovf8)
    );

    serial_addsub #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .sub   (sub3),
        .a     (a3),
        .b     (b3),
        .c_in  (c_in3),
        .busy  (busy3),
        .done  (done3),
        .s     (s3),
        .c_out (c_out3),
        .ovf   (ovf3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain w-bit arithmetic. Returns {ovf, c_out, s[63:0]}.
    function automatic logic [65:0] model(input int w, input logic [63:0] ai,
                                          input logic [63:0] bi, input logic subi,
                                          input logic cini);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] am, bb, sm;
        logic        ci, co, ov;
        mask = (65'd1 << w) - 65'd1;
        am   = ai & mask[63:0];
        bb   = subi ? (~bi & mask[63:0]) : (bi & mask[63:0]);
        ci   = subi ? 1'b1 : cini;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, ci};
        sm   = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    // Called at a negedge with dut8 idle or in its done cycle. Returns at
    // the negedge of the done cycle. hold keeps start=1, a=AA during the run.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                       input logic subi, input logic cini, input logic hold);
        logic [65:0] m;
        logic [9:0]  e;
        int          cyc;
        int          busy_cyc;
        logic        seen;
        m = model(8, {56'd0, ai}, {56'd0, bi}, subi, cini);
        exp_q.push_back({m[65], m[64], m[7:0]});
        a8 = ai; b8 = bi; sub8 = subi; c_in8 = cini; start8 = 1'b1;
        cyc = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && cyc < 14) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                start8 = 1'b1;
                a8     = 8'hAA;
            end else begin
                start8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); c_in8 = 1'($urandom);
            end
            if (done8) begin
                seen = 1'b1;
            end else begin
                if (busy8) busy_cyc++;
                chk("s_held8", 64'(s8), 64'(last_s8));
            end
        end
        start8 = 1'b0;
        // done is seen WIDTH edges after the start edge, i.e. the 9th negedge.
        chk("done_lat8", 64'(cyc), 64'd9);
        chk("busy_cycles8", 64'(busy_cyc), 64'd8);
        chk("busy_at_done8", 64'(busy8), 64'd0);
        e = exp_q.pop_front();
        chk("s8", 64'(s8), 64'(e[7:0]));
        chk("c_out8", 64'(c_out8), 64'(e[8]));
        chk("ovf8", 64'(ovf8), 64'(e[9]));
        last_s8 = e[7:0];
    endtask

    task automatic op3(input logic [2:0] ai, input logic [2:0] bi,
                       input logic subi, input logic cini);
        logic [65:0] m;
        int          cyc;
        logic        seen;
        m = model(3, {61'd0, ai}, {61'd0, bi}, subi, cini);
        a3 = ai; b3 = bi; sub3 = subi; c_in3 = cini; start3 = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            start3 = 1'b0;
            a3 = 3'($urandom); b3 = 3'($urandom);
            if (done3) seen = 1'b1;
            else begin
                chk("busy3", 64'(busy3), 64'd1);
                chk("s_held3", 64'(s3), 64'(last_s3));
            end
        end
        chk("done_lat3", 64'(cyc), 64'd4);
        chk("s3", 64'(s3), 64'(m[2:0]));
        chk("c_out3", 64'(c_out3), 64'(m[64]));
        chk("ovf3", 64'(ovf3), 64'(m[65]));
        last_s3 = m[2:0];
    endtask

    initial begin
        logic no_done;
        vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, cin: 1'b0, s: 8'h96, c: 1'b0, v: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, cin: 1'b1, s: 8'h01, c: 1'b1, v: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, cin: 1'b0, s: 8'hF0, c: 1'b0, v: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, cin: 1'b0, s: 8'h7F, c: 1'b1, v: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h00, sub: 1'b0, cin: 1'b0, s: 8'h00, c: 1'b0, v: 1'b0};
        vecs[5] = '{a: 8'h05, b: 8'h05, sub: 1'b1, cin: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, cin: 1'b0, s: 8'h80, c: 1'b0, v: 1'b1};
        vecs[7] = '{a: 8'h00, b: 8'h01, sub: 1'b1, cin: 1'b1, s: 8'hFF, c: 1'b0, v: 1'b0};

        // Reset
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; c_in8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; sub3 = 1'b0; c_in3 = 1'b0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_s8", 64'(s8), 64'd0);
        chk("rst_c_out8", 64'(c_out8), 64'd0);
        chk("rst_ovf8", 64'(ovf8), 64'd0);
        chk("rst_busy3", 64'(busy3), 64'd0);
        chk("rst_done3", 64'(done3), 64'd0);
        chk("rst_s3", 64'(s3), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0);
            chk("tbl_s8", 64'(s8), 64'(vecs[i].s));
            chk("tbl_c_out8", 64'(c_out8), 64'(vecs[i].c));
            chk("tbl_ovf8", 64'(ovf8), 64'(vecs[i].v));
            @(negedge clk);
            chk("done_single8", 64'(done8), 64'd0);
        end

        // start held through the run is ignored; then back-to-back start
        // in the done cycle.
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("hold_s8", 64'(s8), 64'h02);
        op8(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
        chk("b2b_s8", 64'(s8), 64'h07);
        @(negedge clk);
        chk("done_single_b2b8", 64'(done8), 64'd0);

        // Reset mid-run, with a start presented alongside rst.
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; c_in8 = 1'b0; start8 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1; start8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        chk("abort_busy8", 64'(busy8), 64'd0);
        chk("abort_done8", 64'(done8), 64'd0);
        chk("abort_s8", 64'(s8), 64'd0);
        chk("abort_c_out8", 64'(c_out8), 64'd0);
        chk("abort_ovf8", 64'(ovf8), 64'd0);
        no_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) no_done = 1'b0;
        end
        chk("abort_quiet8", 64'(no_done), 64'd1);
        last_s8 = '0;
        last_s3 = '0;
        op8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("post_abort_s8", 64'(s8), 64'h03);
        @(negedge clk);

        // Random operations, some chained into the done cycle.
        for (int i = 0; i < 30; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 2) != 0) begin
                @(negedge clk);
                chk("done_single_rnd8", 64'(done8), 64'd0);
            end
        end

        // Narrow instance
        op3(3'b111, 3'b001, 1'b0, 1'b0);
        chk("w3_s", 64'(s3), 64'd0);
        chk("w3_c_out", 64'(c_out3), 64'd1);
        chk("w3_ovf", 64'(ovf3), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op3(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
